vp_key_event_arb: RTL and testbench

//  Merges PS/2 key events and gamepad numpad presses into one serial event stream for vp_keymap.
//  The stream is rx_data_ready/rx_ascii/rx_released. Replaces the ad-hoc top-level merge, which

---
 rtl/vp_keyev_pkg.sv | 88 ++++++++
 rtl/vp_keyev_fifo.sv | 57 +++++
 rtl/vp_key_event_arb.sv | 226 ++++++++++++++++++++++
 tb/tb_vp_key_event_arb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_keyev_pkg.sv
// Shared types and lookup tables for the key event arbiter.
// Scan codes are PS/2 set 2 make codes. The extended-prefix bit is not used for lookup.
package vp_keyev_pkg;

    // One queued key event.
    typedef struct packed {
        logic       released;
        logic [7:0] ascii;
    } key_ev_t;

    // Result of a scan-code lookup. hit=0 means the code has no mapping.
    typedef struct packed {
        logic       hit;
        logic [7:0] ascii;
    } ps2_map_t;

    // Output sequencer states.
    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_WAIT = 1'b1
    } seq_state_e;

    localparam int JOY_BITS = 10;

    // Gamepad numpad codes. Index 0 is "1" ... index 8 is "9", and index 9 is "0".
    localparam logic [JOY_BITS-1:0][7:0] JOY_ASCII = {
        8'h30, 8'h39, 8'h38, 8'h37, 8'h36,
        8'h35, 8'h34, 8'h33, 8'h32, 8'h31
    };

    // Translate a PS/2 set 2 make code into the code that vp_keymap expects.
    function automatic ps2_map_t ps2_to_ascii(input logic [7:0] code);
        ps2_map_t r;
        r.hit   = 1'b1;
        r.ascii = 8'h00;
        case (code)
            8'h45: r.ascii = 8'h30;
            8'h16: r.ascii = 8'h31;
            8'h1E: r.ascii = 8'h32;
            8'h26: r.ascii = 8'h33;
            8'h25: r.ascii = 8'h34;
            8'h2E: r.ascii = 8'h35;
            8'h36: r.ascii = 8'h36;
            8'h3D: r.ascii = 8'h37;
            8'h3E: r.ascii = 8'h38;
            8'h46: r.ascii = 8'h39;
            8'h1C: r.ascii = 8'h61;
            8'h32: r.ascii = 8'h62;
            8'h21: r.ascii = 8'h63;
            8'h23: r.ascii = 8'h64;
            8'h24: r.ascii = 8'h65;
            8'h2B: r.ascii = 8'h66;
            8'h34: r.ascii = 8'h67;
            8'h33: r.ascii = 8'h68;
            8'h43: r.ascii = 8'h69;
            8'h3B: r.ascii = 8'h6A;
            8'h42: r.ascii = 8'h6B;
            8'h4B: r.ascii = 8'h6C;
            8'h3A: r.ascii = 8'h6D;
            8'h31: r.ascii = 8'h6E;
            8'h44: r.ascii = 8'h6F;
            8'h4D: r.ascii = 8'h70;
            8'h15: r.ascii = 8'h71;
            8'h2D: r.ascii = 8'h72;
            8'h1B: r.ascii = 8'h73;
            8'h2C: r.ascii = 8'h74;
            8'h3C: r.ascii = 8'h75;
            8'h2A: r.ascii = 8'h76;
            8'h1D: r.ascii = 8'h77;
            8'h22: r.ascii = 8'h78;
            8'h35: r.ascii = 8'h79;
            8'h1A: r.ascii = 8'h7A;
            8'h29: r.ascii = 8'h20;     // space
            8'h79: r.ascii = 8'h2B;     // keypad +
            8'h4E: r.ascii = 8'h2D;     // -
            8'h7C: r.ascii = 8'h2A;     // keypad *
            8'h4A: r.ascii = 8'h2F;     // /
            8'h55: r.ascii = 8'h3D;     // =
            8'h1F: r.ascii = 8'h11;     // left GUI
            8'h27: r.ascii = 8'h12;     // right GUI
            8'h5A: r.ascii = 8'h0A;     // enter
            8'h66: r.ascii = 8'h08;     // backspace
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vp_keyev_fifo.sv
// First-word-fall-through FIFO of key events. The head entry is visible combinationally,
// so the sequencer can pop and present an event in the same cycle.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module vp_keyev_fifo
    import vp_keyev_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  key_ev_t push_data_i,
    input  logic    pop_i,
    output key_ev_t head_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int AW = $clog2(DEPTH);

    key_ev_t     mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    // The extra pointer bit separates the full case from the empty case.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Advance the pointers on accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers. Reset empties the queue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write. The storage needs no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/vp_key_event_arb.sv
// Merges PS/2 key events and gamepad numpad buttons into the single
// rx_data_ready/rx_ascii/rx_released stream consumed by vp_keymap.
// Optional feature: define VP_KEYEV_REPEAT_FILTER_EN to drop typematic repeats of the held PS/2 key.
module vp_key_event_arb
    import vp_keyev_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYC    = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key_i,
    input  logic [9:0]  joy_numpad_i,
    output logic        rx_data_ready_o,
    output logic [7:0]  rx_ascii_o,
    output logic        rx_released_o,
    output logic        overflow_o
);
    localparam int                GAP_W    = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    // PS/2 capture
    logic           ps2_t_q;
    logic           first_q;
    ps2_map_t       ps2_map;
    logic           ps2_toggle;
    logic           ps2_pressed;
    logic           ps2_repeat;
    logic           ps2_want;
    logic           unused_ext;

    // gamepad capture
    logic [JOY_BITS-1:0] joy_prev_q;
    logic [JOY_BITS-1:0] pend_q, pend_d;
    logic [JOY_BITS-1:0] pend_all;
    logic [JOY_BITS-1:0] joy_onehot;
    logic                joy_any;
    logic [3:0]          joy_idx;
    logic                joy_push;

    // queue and sequencer
    logic            fifo_room;
    logic            fifo_push;
    key_ev_t         fifo_din;
    key_ev_t         fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            seq_pop;
    seq_state_e      state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic            overflow_q, overflow_d;
    logic            ready_q;
    logic [7:0]      ascii_q;
    logic            released_q;

    assign unused_ext  = ps2_key_i[8];
    assign ps2_map     = ps2_to_ascii(ps2_key_i[7:0]);
    assign ps2_pressed = ps2_key_i[9];
    assign ps2_toggle  = !first_q && (ps2_key_i[10] != ps2_t_q);

    // Track the toggle bit. The first cycle after reset only primes ps2_t_q.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ps2_t_q <= 1'b0;
            first_q <= 1'b1;
        end else begin
            ps2_t_q <= ps2_key_i[10];
            first_q <= 1'b0;
        end
    end

`ifdef VP_KEYEV_REPEAT_FILTER_EN
    logic [7:0] last_make_q, last_make_d;

    // Detect a repeat of the held key and maintain the held-key register.
    // Mapped codes are never 0x00, so 0x00 means that no key is held.
    always_comb begin
        ps2_repeat  = ps2_pressed && (ps2_map.ascii == last_make_q);
        last_make_d = last_make_q;
        if (ps2_toggle && ps2_map.hit) begin
            if (ps2_pressed)                          last_make_d = ps2_map.ascii;
            else if (ps2_map.ascii == last_make_q)    last_make_d = 8'h00;
        end
    end

    // Register for the last PS/2 make that is still held.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) last_make_q <= 8'h00;
        else        last_make_q <= last_make_d;
    end
`else
    assign ps2_repeat = 1'b0;
`endif

    assign ps2_want = ps2_toggle && ps2_map.hit && !ps2_repeat;

    // pend_all marks the buttons whose state differs from the state last reported.
    // An XOR is used so that a press and release before service cancel out.
    assign pend_all = pend_q ^ (joy_numpad_i ^ joy_prev_q);

    // Select the lowest-numbered pending button.
    always_comb begin
        joy_any = 1'b0;
        joy_idx = '0;
        for (int i = JOY_BITS - 1; i >= 0; i--) begin
            if (pend_all[i]) begin
                joy_any = 1'b1;
                joy_idx = 4'(i);
            end
        end
    end

    assign fifo_room = !fifo_full || seq_pop;
    assign joy_push  = joy_any && !ps2_want && fifo_room;

    // A pending bit is cleared only when its event enters the queue.
    for (genvar gi = 0; gi < JOY_BITS; gi++) begin : g_pend
        assign joy_onehot[gi] = joy_push && (joy_idx == 4'(gi));
        assign pend_d[gi]     = pend_all[gi] && !joy_onehot[gi];
    end

    // Gamepad history and pending set. After reset, held buttons appear as new presses.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            joy_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            joy_prev_q <= joy_numpad_i;
            pend_q     <= pend_d;
        end
    end

    // One write per cycle. PS/2 has priority, and a PS/2 event with no room is lost.
    always_comb begin
        fifo_push  = 1'b0;
        fifo_din   = '0;
        overflow_d = overflow_q;
        if (ps2_want) begin
            fifo_din = '{released: !ps2_pressed, ascii: ps2_map.ascii};
            if (fifo_room) fifo_push  = 1'b1;
            else           overflow_d = 1'b1;
        end else if (joy_push) begin
            fifo_push = 1'b1;
            fifo_din  = '{released: !joy_numpad_i[joy_idx], ascii: JOY_ASCII[joy_idx]};
        end
    end

    // Sticky flag for dropped PS/2 events.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    vp_keyev_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_sys),
        .rst_i       (reset),
        .push_i      (fifo_push),
        .push_data_i (fifo_din),
        .pop_i       (seq_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Sequencer state register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Sequencer next state. WAIT leaves when the counter reaches 0, so strobes are GAP_CYC apart.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            SEQ_IDLE: begin
                if (seq_pop) begin
                    gap_d   = GAP_LOAD;
                    state_d = (GAP_CYC > 1) ? SEQ_WAIT : SEQ_IDLE;
                end
            end
            SEQ_WAIT: begin
                if (gap_q > GAP_W'(1)) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    gap_d   = '0;
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // Sequencer outputs. Pop the head when the sequencer is idle and the gap has expired.
    always_comb begin
        seq_pop = (state_q == SEQ_IDLE) && !fifo_empty && (gap_q == '0);
    end

    // Output registers. The strobe lasts one cycle, and the code and flag hold until the next event.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ready_q    <= 1'b0;
            ascii_q    <= 8'h00;
            released_q <= 1'b0;
        end else begin
            ready_q <= seq_pop;
            if (seq_pop) begin
                ascii_q    <= fifo_head.ascii;
                released_q <= fifo_head.released;
            end
        end
    end

    assign rx_data_ready_o = ready_q;
    assign rx_ascii_o      = ascii_q;
    assign rx_released_o   = released_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_vp_key_event_arb.sv
// Testbench for vp_key_event_arb. A reference model predicts the exact cycle of each strobe,
// and a monitor consumes those predictions.
module tb_vp_key_event_arb;
    localparam int DEPTH = 8;
    localparam int GAP   = 16;

    typedef struct packed {
        logic       rel;
        logic [7:0] ascii;
    } exp_t;

    typedef struct {
        exp_t ev;
        int   cyc;
    } log_t;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [9:0]  joy     = '0;
    logic        rx_data_ready_o;
    logic [7:0]  rx_ascii_o;
    logic        rx_released_o;
    logic        overflow_o;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic [7:0] kmap [logic [7:0]];
    exp_t       m_fifo[$];
    exp_t       sb[$];
    log_t       log_q[$];
    int         cyc = 0;
    int         m_last_pop = -1000;
    logic       m_first = 1'b1;
    logic       m_ps2_t = 1'b0;
    logic [9:0] m_reported = '0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_last_make = 8'h00;

    always #5 clk_sys = ~clk_sys;

    vp_key_event_arb #(
        .FIFO_DEPTH      (DEPTH),
        .GAP_CYC         (GAP)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .ps2_key_i       (ps2_key),
        .joy_numpad_i    (joy),
        .rx_data_ready_o (rx_data_ready_o),
        .rx_ascii_o      (rx_ascii_o),
        .rx_released_o   (rx_released_o),
        .overflow_o      (overflow_o)
    );

    // Reference model. The queue holds at most DEPTH entries. It pops when the gap has elapsed,
    // then gives the cycle's one write to PS/2 before the gamepad.
    always @(posedge clk_sys) begin
        exp_t       e;
        logic [7:0] asc;
        logic       want;
        logic       rpt;
        cyc++;
        if (reset) begin
            m_fifo.delete();
            sb.delete();
            m_last_pop  = -1000;
            m_first     = 1'b1;
            m_ps2_t     = 1'b0;
            m_reported  = '0;
            m_ovf       = 1'b0;
            m_last_make = 8'h00;
        end else begin
            if (m_fifo.size() != 0 && (cyc - m_last_pop) >= GAP) begin
                e = m_fifo.pop_front();
                sb.push_back(e);
                m_last_pop = cyc;
            end
            want = 1'b0;
            if (m_first) begin
                m_first = 1'b0;
            end else if (ps2_key[10] != m_ps2_t && kmap.exists(ps2_key[7:0])) begin
                asc = kmap[ps2_key[7:0]];
                rpt = 1'b0;
`ifdef VP_KEYEV_REPEAT_FILTER_EN
                rpt = ps2_key[9] && (asc == m_last_make);
                if (ps2_key[9])                m_last_make = asc;
                else if (asc == m_last_make)   m_last_make = 8'h00;
`endif
                if (!rpt) begin
                    want = 1'b1;
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(exp_t'({~ps2_key[9], asc}));
                    else                       m_ovf = 1'b1;
                end
            end
            m_ps2_t = ps2_key[10];
            if (!want) begin
                for (int i = 0; i < 10; i++) begin
                    if (joy[i] != m_reported[i]) begin
                        if (m_fifo.size() < DEPTH) begin
                            asc = (i == 9) ? 8'h30 : 8'(8'h31 + i);
                            m_fifo.push_back(exp_t'({~joy[i], asc}));
                            m_reported[i] = joy[i];
                        end
                        break;
                    end
                end
            end
        end
    end

    // Monitor. Each predicted strobe must appear in the cycle in which the model popped it.
    always @(posedge clk_sys) begin
        exp_t e;
        #1;
        if (rx_data_ready_o || sb.size() != 0) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: got ascii=%02h rel=%0b, required no strobe", rx_ascii_o, rx_released_o);
            end else begin
                e = sb.pop_front();
                if (!rx_data_ready_o) begin
                    miscompares++;
                    $display("FAIL missing_strobe: got none, required ascii=%02h rel=%0b", e.ascii, e.rel);
                end else if (rx_ascii_o !== e.ascii || rx_released_o !== e.rel) begin
                    miscompares++;
                    $display("FAIL event: got ascii=%02h rel=%0b, required ascii=%02h rel=%0b",
                             rx_ascii_o, rx_released_o, e.ascii, e.rel);
                end
            end
        end
        if (rx_data_ready_o === 1'b1) log_q.push_back('{ev: exp_t'({rx_released_o, rx_ascii_o}), cyc: cyc});
        vectors++;
        if (overflow_o !== m_ovf) begin
            miscompares++;
            $display("FAIL overflow: got %0b, required %0b", overflow_o, m_ovf);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic ps2_send(input logic [7:0] code, input logic pressed);
        @(negedge clk_sys);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(2);
        while ((m_fifo.size() != 0 || m_reported != joy) && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        check("drain_timeout", n < 1000, 1);
        idle(GAP + 4);
    endtask

    initial begin
        logic [7:0] burst [12];
        logic [7:0] rnd_codes [10];
        logic [7:0] t3 [3];
        int         exp6;

        burst = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45, 8'h1C, 8'h32};
        rnd_codes = '{8'h1C, 8'h29, 8'h5A, 8'h66, 8'h1F, 8'h79, 8'h45, 8'h76, 8'h05, 8'h7C};
        t3 = '{8'h31, 8'h35, 8'h30};

        kmap[8'h45] = 8'h30; kmap[8'h16] = 8'h31; kmap[8'h1E] = 8'h32; kmap[8'h26] = 8'h33;
        kmap[8'h25] = 8'h34; kmap[8'h2E] = 8'h35; kmap[8'h36] = 8'h36; kmap[8'h3D] = 8'h37;
        kmap[8'h3E] = 8'h38; kmap[8'h46] = 8'h39;
        kmap[8'h1C] = "a"; kmap[8'h32] = "b"; kmap[8'h21] = "c"; kmap[8'h23] = "d";
        kmap[8'h24] = "e"; kmap[8'h2B] = "f"; kmap[8'h34] = "g"; kmap[8'h33] = "h";
        kmap[8'h43] = "i"; kmap[8'h3B] = "j"; kmap[8'h42] = "k"; kmap[8'h4B] = "l";
        kmap[8'h3A] = "m"; kmap[8'h31] = "n"; kmap[8'h44] = "o"; kmap[8'h4D] = "p";
        kmap[8'h15] = "q"; kmap[8'h2D] = "r"; kmap[8'h1B] = "s"; kmap[8'h2C] = "t";
        kmap[8'h3C] = "u"; kmap[8'h2A] = "v"; kmap[8'h1D] = "w"; kmap[8'h22] = "x";
        kmap[8'h35] = "y"; kmap[8'h1A] = "z";
        kmap[8'h29] = " "; kmap[8'h79] = "+"; kmap[8'h4E] = "-"; kmap[8'h7C] = "*";
        kmap[8'h4A] = "/"; kmap[8'h55] = "="; kmap[8'h1F] = 8'h11; kmap[8'h27] = 8'h12;
        kmap[8'h5A] = 8'h0A; kmap[8'h66] = 8'h08;

        // reset state
        idle(3);
        check("rst_ready", rx_data_ready_o, 0);
        check("rst_ascii", rx_ascii_o, 0);
        check("rst_released", rx_released_o, 0);
        check("rst_overflow", overflow_o, 0);
        reset = 1'b0;
        idle(3);

        // 1) press and release "a". Check the two-cycle latency and the spacing.
        log_q.delete();
        ps2_send(8'h1C, 1'b1);
        @(posedge clk_sys);
        @(posedge clk_sys);
        #2;
        check("t1_latency_strobe", rx_data_ready_o, 1);
        check("t1_latency_ascii", rx_ascii_o, 8'h61);
        idle(3);
        ps2_send(8'h1C, 1'b0);
        drain();
        check("t1_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t1_first", log_q[0].ev, 9'h061);
            check("t1_second", log_q[1].ev, 9'h161);
            check("t1_spacing", (log_q[1].cyc - log_q[0].cyc) >= GAP, 1);
        end

        // 2) PS/2 "5" press and gamepad "3" press in the same cycle
        log_q.delete();
        @(negedge clk_sys);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h2E};
        joy     = 10'b00_0000_0100;
        drain();
        check("t2_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t2_first", log_q[0].ev, 9'h035);
            check("t2_second", log_q[1].ev, 9'h033);
            check("t2_spacing", (log_q[1].cyc - log_q[0].cyc) >= GAP, 1);
        end
        joy = '0;
        drain();

        // 3) gamepad bits 0, 4 and 9 rise together, then all drop
        log_q.delete();
        @(negedge clk_sys);
        joy = 10'b10_0001_0001;
        drain();
        @(negedge clk_sys);
        joy = '0;
        drain();
        check("t3_count", log_q.size(), 6);
        if (log_q.size() == 6) begin
            for (int i = 0; i < 3; i++) begin
                check("t3_press", log_q[i].ev, {1'b0, t3[i]});
                check("t3_release", log_q[i+3].ev, {1'b1, t3[i]});
            end
        end

        // 4) burst of 12 PS/2 events, with one gamepad press in the middle
        log_q.delete();
        for (int i = 0; i < 12; i++) begin
            ps2_send(burst[i], 1'b1);
            if (i == 5) joy = 10'b00_0010_0000;
        end
        drain();
        check("t4_overflow", overflow_o, 1);
        check("t4_count", log_q.size(), 10);
        if (log_q.size() == 10) begin
            for (int i = 0; i < 9; i++) check("t4_order", log_q[i].ev, {1'b0, kmap[burst[i]]});
            check("t4_joy", log_q[9].ev, 9'h036);
        end
        joy = '0;
        drain();

        // 5) an unmapped code gives no strobe, and reset discards the queued events
        log_q.delete();
        ps2_send(8'h76, 1'b1);
        idle(GAP + 4);
        check("t5_unmapped", log_q.size(), 0);
        for (int i = 0; i < 4; i++) ps2_send(burst[i], 1'b1);
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        check("t5_rst_ready", rx_data_ready_o, 0);
        check("t5_rst_ascii", rx_ascii_o, 0);
        check("t5_rst_released", rx_released_o, 0);
        check("t5_rst_overflow", overflow_o, 0);
        idle(2);
        reset = 1'b0;
        log_q.delete();
        idle(4 * GAP);
        check("t5_flushed", log_q.size(), 0);

        // 6) press "a" three times, then release it
        log_q.delete();
        for (int i = 0; i < 3; i++) begin
            ps2_send(8'h1C, 1'b1);
            idle(3);
        end
        ps2_send(8'h1C, 1'b0);
        drain();
`ifdef VP_KEYEV_REPEAT_FILTER_EN
        exp6 = 2;
`else
        exp6 = 4;
`endif
        check("t6_count", log_q.size(), exp6);

        // random mix of PS/2 and gamepad traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_sys);
            if ($urandom_range(3, 0) == 0)
                ps2_key = {~ps2_key[10], 1'($urandom_range(1, 0)), 1'b0,
                           rnd_codes[$urandom_range(9, 0)]};
            if ($urandom_range(7, 0) == 0)
                joy = joy ^ (10'd1 << $urandom_range(9, 0));
        end
        drain();
        @(negedge clk_sys);
        joy = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
